// File: rtl/led_fade_driver_if.sv
// Signal bundle between the Nios LED PIO side and led_fade_driver.
// The master drives the target pattern and fade enable; the slave returns the LED drive and busy flag.
interface led_fade_driver_if #(
    parameter int NUM_LEDS = 8
);
    logic [NUM_LEDS-1:0] led_wire_export;
    logic                fade_en;
    logic [NUM_LEDS-1:0] led_out;
    logic                fade_busy;

    modport master (
        output led_wire_export,
        output fade_en,
        input  led_out,
        input  fade_busy
    );

    modport slave (
        input  led_wire_export,
        input  fade_en,
        output led_out,
        output fade_busy
    );
endinterface

// File: rtl/led_fade_driver.sv
// Per-LED PWM driver that ramps brightness linearly toward the PIO on/off target.
// Optional LED_FADE_GAMMA_EN maps brightness to a quadratic duty curve.
module led_fade_driver #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 50000
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    led_fade_driver_if.slave   bus
);
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] BMAX     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = BMAX - {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [NUM_LEDS-1:0] target_q, target_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] bright_q [NUM_LEDS];
    logic [PWM_BITS-1:0] bright_d [NUM_LEDS];
    logic [PWM_BITS-1:0] tgt_s    [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;
    logic                fade_busy_q, fade_busy_d;
    logic                step_tick_s;

    // Brightness to PWM duty; the gamma curve keeps both endpoints fixed.
    function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] b);
`ifdef LED_FADE_GAMMA_EN
        logic [2*PWM_BITS-1:0] wide;
        logic [2*PWM_BITS-1:0] prod;
        wide = {{PWM_BITS{1'b0}}, b};
        prod = (wide * wide) + wide;
        return prod[2*PWM_BITS-1:PWM_BITS];
`else
        return b;
`endif
    endfunction

    // Full-scale or zero target per channel from the registered PIO pattern.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            tgt_s[i] = target_q[i] ? BMAX : {PWM_BITS{1'b0}};
        end
    end

    // Free-running step prescaler and PWM period counter (period BMAX, never reaches BMAX).
    always_comb begin
        target_d    = bus.led_wire_export;
        step_tick_s = (presc_q == PRE_LAST);
        if (step_tick_s) begin
            presc_d = {PRE_W{1'b0}};
        end else begin
            presc_d = presc_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
        if (pwm_cnt_q >= PWM_LAST) begin
            pwm_cnt_d = {PWM_BITS{1'b0}};
        end else begin
            pwm_cnt_d = pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Per-channel ramp/snap, PWM compare and busy detection.
    always_comb begin
        fade_busy_d = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            fade_busy_d  = fade_busy_d | (bright_q[i] != tgt_s[i]);
            led_out_d[i] = (pwm_cnt_q < duty_of(bright_q[i]));
            if (!bus.fade_en) begin
                bright_d[i] = tgt_s[i];
            end else if (step_tick_s) begin
                if (bright_q[i] < tgt_s[i]) begin
                    bright_d[i] = bright_q[i] + {{(PWM_BITS-1){1'b0}}, 1'b1};
                end else if (bright_q[i] > tgt_s[i]) begin
                    bright_d[i] = bright_q[i] - {{(PWM_BITS-1){1'b0}}, 1'b1};
                end else begin
                    bright_d[i] = bright_q[i];
                end
            end else begin
                bright_d[i] = bright_q[i];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            target_q    <= {NUM_LEDS{1'b0}};
            presc_q     <= {PRE_W{1'b0}};
            pwm_cnt_q   <= {PWM_BITS{1'b0}};
            led_out_q   <= {NUM_LEDS{1'b0}};
            fade_busy_q <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                bright_q[i] <= {PWM_BITS{1'b0}};
            end
        end else begin
            target_q    <= target_d;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_out_q   <= led_out_d;
            fade_busy_q <= fade_busy_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                bright_q[i] <= bright_d[i];
            end
        end
    end

    assign bus.led_out   = led_out_q;
    assign bus.fade_busy = fade_busy_q;
endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Sits directly downstream of the Nios system's 8-bit LED PIO export (led_wire_export).
- Drives the board LEDs with per-LED PWM brightness.
- Each LED's brightness ramps linearly toward full-on or full-off whenever its PIO bit changes, so software writes produce smooth fades instead of hard steps.
- Also reports when any fade is in progress.

Parameters:
- NUM_LEDS, 8: number of LED channels; width of led_wire_export and led_out.
- PWM_BITS, 8: brightness resolution. BMAX = 2^PWM_BITS - 1.
- STEP_DIV, 50000: clk_clk cycles per brightness step. Legal range is 1 or more; a full fade takes BMAX*STEP_DIV cycles.

Ports:
- clk_clk  input  1  system clock (same clock as nios_system).
- reset_reset  input  1  synchronous reset, active-high.
- led_wire_export  input  NUM_LEDS  target on/off pattern from the Nios PIO.
- fade_en  input  1  1 = ramp brightness; 0 = brightness snaps to target.
- led_out  output  NUM_LEDS  PWM LED drive, registered.
- fade_busy  output  1  registered; 1 while any channel's brightness differs from its target.

Behaviour:
- Single clock domain: clk_clk. Reset is synchronous and active-high on reset_reset; all state is sampled on the rising edge.
- Reset values: led_out=0, fade_busy=0, all bright[i]=0, target_q=0, prescaler=0, pwm_cnt=0.
- Reset asserted mid-fade aborts the fade; all state returns to reset values on that edge.
- Input stage:
  - target_q <= led_wire_export every cycle (1-cycle register).
  - tgt[i] = target_q[i] ? BMAX : 0.
- Prescaler:
  - Counts 0..STEP_DIV-1, then wraps to 0.
  - step_tick=1 in the cycle prescaler==STEP_DIV-1.
  - With STEP_DIV=1, step_tick=1 every cycle.
  - Prescaler runs free, independent of fade_en.
- Brightness update, per channel, every cycle:
  - fade_en=0: bright[i] <= tgt[i] (snap, no tick needed).
  - fade_en=1 and step_tick: if bright[i] < tgt[i], increment by 1; if greater, decrement by 1; if equal, hold.
  - Otherwise hold.
  - bright[i] never leaves 0..BMAX; no wrap-around.
  - Target reversal mid-fade: the ramp reverses from the current value on the next tick, with no jump.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) counts 0..BMAX-1, then wraps to 0. Period is BMAX cycles.
  - Value BMAX is never reached, so bright=BMAX gives 100% duty and bright=0 gives 0% duty.
- Output: led_out[i] <= (pwm_cnt < duty[i]), registered.
  - duty[i] = bright[i] when the optional feature is off.
  - Duty cycle is exactly duty[i]/BMAX.
- fade_busy <= OR over i of (bright[i] != tgt[i]), registered from the current bright values.
- Latency:
  - led_wire_export change to target_q: 1 cycle.
  - With fade_en=0: bright updates 1 cycle after target_q, and led_out reflects it 1 cycle later. Total 3 edges from input change.
  - With fade_en=1: the first step occurs on the first step_tick after target_q updates.
- Simultaneous events: a target change and step_tick in the same cycle step toward the new target. A fade_en falling edge during a ramp snaps on the next edge.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty[i] = (bright[i]*bright[i] + bright[i]) >> PWM_BITS, computed with a 2*PWM_BITS-wide product.
  - Approximates perceptual (quadratic) brightness.
  - Endpoints preserved: 0 maps to 0, BMAX maps to BMAX.
  - Adds no cycles of latency; the product is combinational into the output register.
- Not defined: duty[i] = bright[i] (linear). No multiplier is synthesized.

Test Plan:
- Reset: hold reset_reset 3 cycles with led_wire_export=8'hFF, fade_en=1 -> led_out=0 and fade_busy=0 throughout. After release, fade_busy=1 two cycles later.
- Snap mode (PWM_BITS=4, STEP_DIV=4, fade_en=0):
  - Set led_wire_export=8'h01 -> led_out[0] constant 1 from 3 edges after the change; led_out[7:1]=0; fade_busy=0 after settling.
- Linear ramp (PWM_BITS=4, STEP_DIV=4, fade_en=1):
  - Set 8'h01 -> bright[0] reaches 15 after exactly 15 ticks (60 cycles, ±4 for prescaler phase); fade_busy=1 during the ramp, then 0.
  - At bright=5, led_out[0] is high 5 of every 15 cycles.
- Reversal: during the ramp up at bright=9, set 8'h00 -> next tick gives bright=8, with no jump; reaches 0 after 9 ticks. led_out[0]=0 continuously once bright=0.
- Boundary duty:
  - bright=15 -> led_out high for all 15 cycles of the period, never low.
  - bright=0 -> never high.
  - With LED_FADE_GAMMA_EN: bright=8 gives duty (64+8)>>4=4, i.e. high 4 of every 15 cycles.
- Reset mid-fade: assert reset_reset at bright=7 -> next edge bright=0, led_out=0, fade_busy=0. After release with target still 8'h01, the ramp restarts from 0.
